// File: rtl/dffram_pkg.sv
// rtl/dffram_pkg.sv - shared types and constants for the DFF RAM byte sequencer
package dffram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2,
    RD    = 2'd3
  } state_t;

  localparam int PKG_DWIDTH = 4;
  localparam int BYTEWIDTH  = 2 * PKG_DWIDTH;
  localparam int NREQ       = 2;

  localparam logic LOHI_LO = 1'b0;
  localparam logic LOHI_HI = 1'b1;

endpackage

// File: rtl/dffram_rr_arb2.sv
// rtl/dffram_rr_arb2.sv - two-way round-robin arbiter, pointer moves only on a grant
module dffram_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  logic r_ptr;

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (req == 2'b11) gnt = r_ptr ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  // The winner loses priority to the other requester next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_ptr <= 1'b0;
    else if (gnt[0]) r_ptr <= 1'b1;
    else if (gnt[1]) r_ptr <= 1'b0;
  end

endmodule

// File: rtl/dffram_byte_sequencer.sv
// rtl/dffram_byte_sequencer.sv - byte read/write sequencing onto a nibble-wide 2R1W DFF RAM
module dffram_byte_sequencer
  import dffram_pkg::*;
#(
  parameter int AWIDTH = 4,
  parameter int DWIDTH = PKG_DWIDTH
) (
  input  logic [0:0]            clk,
  input  logic [0:0]            rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_we,
  input  logic [2*AWIDTH-1:0]   req_addr,
  input  logic [2*2*DWIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [2*DWIDTH-1:0]   rsp_data,
  output logic [AWIDTH-1:0]     ram_addr_a,
  output logic [DWIDTH-1:0]     ram_wdata_a,
  output logic                  ram_lohi_a,
  output logic                  ram_w_en,
  output logic [AWIDTH-1:0]     ram_addr_b,
  output logic                  ram_lohi_b,
  input  logic [DWIDTH-1:0]     ram_rdata_a,
  input  logic [DWIDTH-1:0]     ram_rdata_b
);

  state_t                r_state;
  logic                  r_owner;
  logic [AWIDTH-1:0]     r_addr;
  logic [2*DWIDTH-1:0]   r_wdata;

  logic [1:0]            w_gnt;
  logic                  w_sel;
  logic                  w_we;
  logic [AWIDTH-1:0]     w_addr;
  logic [2*DWIDTH-1:0]   w_wdata;

  dffram_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .enable (r_state == IDLE),
    .gnt    (w_gnt)
  );

  assign req_ready = w_gnt;
  assign w_sel     = w_gnt[1];
  assign w_we      = w_sel ? req_we[1] : req_we[0];
  assign w_addr    = w_sel ? req_addr[2*AWIDTH-1:AWIDTH] : req_addr[AWIDTH-1:0];
  assign w_wdata   = w_sel ? req_wdata[4*DWIDTH-1:2*DWIDTH] : req_wdata[2*DWIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      ram_addr_a  <= '0;
      ram_wdata_a <= '0;
      ram_lohi_a  <= LOHI_LO;
      ram_w_en    <= 1'b0;
      ram_addr_b  <= '0;
      ram_lohi_b  <= LOHI_LO;
    end else begin
      rsp_valid <= '0;
      case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_owner    <= w_sel;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
            ram_addr_a <= w_addr;
            ram_lohi_a <= LOHI_LO;
            if (w_we) begin
              ram_wdata_a <= w_wdata[DWIDTH-1:0];
              ram_w_en    <= 1'b1;
              r_state     <= WR_LO;
            end else begin
              ram_addr_b <= w_addr;
              ram_lohi_b <= LOHI_HI;
              ram_w_en   <= 1'b0;
              r_state    <= RD;
            end
          end
        end
        WR_LO: begin
          ram_addr_a  <= r_addr;
          ram_wdata_a <= r_wdata[2*DWIDTH-1:DWIDTH];
          ram_lohi_a  <= LOHI_HI;
          ram_w_en    <= 1'b1;
          r_state     <= WR_HI;
        end
        WR_HI: begin
          ram_w_en           <= 1'b0;
          ram_lohi_a         <= LOHI_LO;
          rsp_valid[r_owner] <= 1'b1;
          rsp_data           <= r_wdata;
          r_state            <= IDLE;
        end
        RD: begin
          // Both nibbles are read in the same cycle through the two read ports.
          ram_lohi_b         <= LOHI_LO;
          rsp_data           <= {ram_rdata_b, ram_rdata_a};
          rsp_valid[r_owner] <= 1'b1;
          r_state            <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dffram_byte_sequencer.sv
// tb/tb_dffram_byte_sequencer.sv - scoreboard bench with RAM model and random two-requester traffic
module tb_dffram_byte_sequencer;

  typedef struct {
    bit         we;
    logic [3:0] addr;
    logic [7:0] wdata;
    int         gap;
  } cmd_t;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } rsp_t;

  typedef struct {
    int         cyc;
    bit         wr;
    logic [3:0] addr;
    logic [3:0] nib;
    bit         lohi;
  } ram_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_valid = '0;
  logic [1:0] req_ready;
  logic [1:0] req_we = '0;
  logic [7:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0] rsp_valid;
  logic [7:0] rsp_data;
  logic [3:0] ram_addr_a, ram_wdata_a, ram_addr_b, ram_rdata_a, ram_rdata_b;
  logic       ram_lohi_a, ram_w_en, ram_lohi_b;

  logic [7:0] ram_mem [16];
  logic [7:0] ref_mem [16];
  cmd_t       cmd_q [2][$];
  rsp_t       rsp_q [2][$];
  ram_t       ram_q [$];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  bit         ptr_m = 1'b0;
  int         free_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dffram_byte_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .ram_addr_a  (ram_addr_a),
    .ram_wdata_a (ram_wdata_a),
    .ram_lohi_a  (ram_lohi_a),
    .ram_w_en    (ram_w_en),
    .ram_addr_b  (ram_addr_b),
    .ram_lohi_b  (ram_lohi_b),
    .ram_rdata_a (ram_rdata_a),
    .ram_rdata_b (ram_rdata_b)
  );

  // Nibble-wide 2R1W RAM, unbuffered reads.
  always @(posedge clk) begin
    if (ram_w_en) begin
      if (ram_lohi_a) ram_mem[ram_addr_a][7:4] <= ram_wdata_a;
      else            ram_mem[ram_addr_a][3:0] <= ram_wdata_a;
    end
  end
  assign ram_rdata_a = ram_lohi_a ? ram_mem[ram_addr_a][7:4] : ram_mem[ram_addr_a][3:0];
  assign ram_rdata_b = ram_lohi_b ? ram_mem[ram_addr_b][7:4] : ram_mem[ram_addr_b][3:0];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Accepted commands are serialised, so the reference memory is updated in accept order.
  function automatic void accept(input int i, input cmd_t c);
    if (c.we) begin
      ref_mem[c.addr] = c.wdata;
      rsp_q[i].push_back('{cyc + 3, c.wdata});
      ram_q.push_back('{cyc + 1, 1'b1, c.addr, c.wdata[3:0], 1'b0});
      ram_q.push_back('{cyc + 2, 1'b1, c.addr, c.wdata[7:4], 1'b1});
    end else begin
      rsp_q[i].push_back('{cyc + 2, ref_mem[c.addr]});
      ram_q.push_back('{cyc + 1, 1'b0, c.addr, 4'h0, 1'b0});
    end
  endfunction

  task automatic drive(input int i);
    cmd_t c;
    int   tmo;
    forever begin
      @(negedge clk);
      req_valid[i] = 1'b0;
      if (cmd_q[i].size() == 0) continue;
      c = cmd_q[i][0];
      repeat (c.gap) @(negedge clk);
      req_valid[i] = 1'b1;
      req_we[i] = c.we;
      req_addr[i*4 +: 4] = c.addr;
      req_wdata[i*8 +: 8] = c.wdata;
      tmo = 0;
      forever begin
        #1;
        if (req_ready[i] || tmo > 40) break;
        tmo++;
        @(negedge clk);
      end
      if (req_ready[i]) accept(i, c);
      else chk($sformatf("grant_timeout_req%0d", i), 32'd0, 32'd1);
      void'(cmd_q[i].pop_front());
    end
  endtask

  initial begin
    fork
      drive(0);
      drive(1);
    join_none
  end

  // Arbitration model and response/RAM-port monitor.
  always @(negedge clk) begin
    logic [1:0] exp_rdy;
    rsp_t       r;
    ram_t       m;
    int         g;
    #2;
    if (!rst) begin
      exp_rdy = 2'b00;
      if (cyc >= free_cyc) exp_rdy = (req_valid == 2'b11) ? (ptr_m ? 2'b10 : 2'b01) : req_valid;
      chk("req_ready", req_ready, exp_rdy);
      if (exp_rdy != 2'b00) begin
        g = exp_rdy[1] ? 1 : 0;
        ptr_m = (g == 0);
        free_cyc = cyc + (req_we[g] ? 3 : 2);
      end
      for (int i = 0; i < 2; i++) begin
        if (rsp_valid[i]) begin
          if (rsp_q[i].size() == 0) chk($sformatf("rsp_unexpected%0d", i), 32'd1, 32'd0);
          else begin
            r = rsp_q[i].pop_front();
            chk($sformatf("rsp_cycle%0d", i), cyc, r.cyc);
            chk($sformatf("rsp_data%0d", i), rsp_data, r.data);
          end
        end
      end
      if (ram_q.size() != 0 && ram_q[0].cyc == cyc) begin
        m = ram_q.pop_front();
        if (m.wr) chk("ram_write", {ram_w_en, ram_lohi_a, ram_addr_a, ram_wdata_a}, {1'b1, m.lohi, m.addr, m.nib});
        else      chk("ram_read", {ram_w_en, ram_lohi_a, ram_lohi_b, ram_addr_a, ram_addr_b},
                      {1'b0, 1'b0, 1'b1, m.addr, m.addr});
      end else begin
        chk("w_en_idle", ram_w_en, 1'b0);
      end
    end
  end

  task automatic wait_drain();
    int t = 0;
    while ((cmd_q[0].size() + cmd_q[1].size() + rsp_q[0].size() + rsp_q[1].size() + ram_q.size()) != 0
           && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", (t < 3000) ? 32'd1 : 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] old7;
    logic [7:0] nw7;
    int         t;
    for (int k = 0; k < 16; k++) begin
      ref_mem[k] = 8'($urandom);
      ram_mem[k] <= ref_mem[k];
    end
    repeat (2) @(negedge clk);
    #3;
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_w_en", ram_w_en, 1'b0);
    chk("rst_lohi", {ram_lohi_a, ram_lohi_b}, 2'b00);
    chk("rst_ram_out", {ram_addr_a, ram_wdata_a, ram_addr_b}, 12'h000);
    chk("rst_ready", req_ready, 2'b00);
    rst = 1'b0;

    // Contention with reads from reset: grants alternate 0,1,0,1.
    for (int k = 0; k < 2; k++) begin
      cmd_q[0].push_back('{1'b0, 4'd1, 8'h00, 0});
      cmd_q[1].push_back('{1'b0, 4'd2, 8'h00, 0});
    end
    wait_drain();

    cmd_q[0].push_back('{1'b1, 4'd3, 8'hA5, 0});
    wait_drain();
    cmd_q[1].push_back('{1'b0, 4'd3, 8'h00, 0});
    wait_drain();
    chk("readback_ref", rsp_data, 8'hA5);

    // Back-to-back writes from both requesters, then read-after-write across requesters.
    for (int k = 0; k < 3; k++) begin
      cmd_q[0].push_back('{1'b1, 4'(k), 8'($urandom), 0});
      cmd_q[1].push_back('{1'b1, 4'(k + 8), 8'($urandom), 0});
    end
    cmd_q[0].push_back('{1'b0, 4'd8, 8'h00, 0});
    cmd_q[1].push_back('{1'b0, 4'd0, 8'h00, 0});
    wait_drain();

    // Idle: model pointer is unchanged, next contention checks it.
    repeat (10) @(negedge clk);
    cmd_q[0].push_back('{1'b0, 4'd5, 8'h00, 0});
    cmd_q[1].push_back('{1'b0, 4'd6, 8'h00, 0});
    wait_drain();

    // Reset during the high-nibble write.
    old7 = ref_mem[7];
    nw7 = ~old7;
    cmd_q[0].push_back('{1'b1, 4'd7, nw7, 0});
    t = 0;
    do begin
      @(negedge clk);
      #3;
      t++;
    end while (!(ram_w_en && ram_lohi_a) && t < 50);
    chk("wr_hi_reached", (t < 50) ? 32'd1 : 32'd0, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_wrhi_w_en", ram_w_en, 1'b0);
    chk("rst_wrhi_lohi", ram_lohi_a, 1'b0);
    chk("rst_wrhi_rsp", rsp_valid, 2'b00);
    rsp_q[0].delete();
    rsp_q[1].delete();
    ram_q.delete();
    ref_mem[7] = {old7[7:4], nw7[3:0]};
    ptr_m = 1'b0;
    free_cyc = 0;
    @(negedge clk);
    #3;
    rst = 1'b0;
    cmd_q[1].push_back('{1'b0, 4'd7, 8'h00, 0});
    wait_drain();
    chk("partial_write", rsp_data, {old7[7:4], nw7[3:0]});

    // Random traffic.
    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < 2; i++)
        cmd_q[i].push_back('{1'($urandom), 4'($urandom), 8'($urandom), int'($urandom_range(0, 3))});
    end
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
